// File: rtl/tug_match_ctrl.sv
// Match-level sequencer for tug-of-war: scores rounds, holds the playfield in reset between rounds, declares the champion.
// Optional win-by-two scoring is enabled by defining TUG_WIN_BY_TWO_EN.
module tug_match_ctrl #(
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               win_l,
  input  logic               win_r,
  output logic               field_reset,
  output logic               play_en,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_over,
  output logic               champ_l,
  output logic               champ_r
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

`ifdef TUG_WIN_BY_TWO_EN
  localparam logic [SCORE_W-1:0] MAX_VAL = {SCORE_W{1'b1}};

  // Returns {over, new_winner, new_loser}; near the top of the range both scores shift down to keep the lead.
  function automatic logic [2*SCORE_W:0] by_two_step(input logic [SCORE_W-1:0] w,
                                                     input logic [SCORE_W-1:0] o);
    logic [SCORE_W-1:0] nw;
    logic [SCORE_W-1:0] no;
    logic               done;
    if (w == MAX_VAL) begin
      nw = w;
      no = o - SCORE_W'(1);
    end else if ((w + SCORE_W'(1) == MAX_VAL) && (o == MAX_VAL)) begin
      nw = w;
      no = o - SCORE_W'(1);
    end else begin
      nw = w + SCORE_W'(1);
      no = o;
    end
    done = (nw >= WIN_VAL) && ({1'b0, nw} >= ({1'b0, no} + (SCORE_W + 1)'(2)));
    return {done, nw, no};
  endfunction
`endif

  logic [1:0]         state_r;
  logic [1:0]         state_s;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [HOLD_W-1:0]  hold_cnt_s;
  logic [SCORE_W-1:0] score_l_s;
  logic [SCORE_W-1:0] score_r_s;
  logic               field_reset_s;
  logic               play_en_s;
  logic               match_over_s;
  logic               champ_l_s;
  logic               champ_r_s;
  logic               round_over_s;
  logic [SCORE_W-1:0] win_score_l_s;
  logic [SCORE_W-1:0] win_score_r_s;

  // Scores that would result from a single-sided round win, and whether that win ends the match.
  always_comb begin
    win_score_l_s = score_l;
    win_score_r_s = score_r;
    round_over_s  = 1'b0;
`ifdef TUG_WIN_BY_TWO_EN
    if (win_l) begin
      {round_over_s, win_score_l_s, win_score_r_s} = by_two_step(score_l, score_r);
    end else begin
      {round_over_s, win_score_r_s, win_score_l_s} = by_two_step(score_r, score_l);
    end
`else
    if (win_l) begin
      win_score_l_s = score_l + SCORE_W'(1);
      round_over_s  = (win_score_l_s == WIN_VAL);
    end else begin
      win_score_r_s = score_r + SCORE_W'(1);
      round_over_s  = (win_score_r_s == WIN_VAL);
    end
`endif
  end

  // Next-state and next-output logic for the match sequencer.
  always_comb begin
    state_s       = state_r;
    hold_cnt_s    = hold_cnt_r;
    score_l_s     = score_l;
    score_r_s     = score_r;
    field_reset_s = field_reset;
    play_en_s     = play_en;
    match_over_s  = match_over;
    champ_l_s     = champ_l;
    champ_r_s     = champ_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s       = ST_PLAY;
          field_reset_s = 1'b0;
          play_en_s     = 1'b1;
        end else begin
          field_reset_s = 1'b1;
          play_en_s     = 1'b0;
        end
      end
      ST_PLAY: begin
        if (win_l ^ win_r) begin
          score_l_s     = win_score_l_s;
          score_r_s     = win_score_r_s;
          field_reset_s = 1'b1;
          play_en_s     = 1'b0;
          if (round_over_s) begin
            state_s      = ST_OVER;
            match_over_s = 1'b1;
            champ_l_s    = win_l;
            champ_r_s    = win_r;
          end else begin
            state_s    = ST_HOLD;
            hold_cnt_s = HOLD_LOAD;
          end
        end else begin
          field_reset_s = 1'b0;
          play_en_s     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_W'(0)) begin
          state_s       = ST_PLAY;
          field_reset_s = 1'b0;
          play_en_s     = 1'b1;
        end else begin
          hold_cnt_s = hold_cnt_r - HOLD_W'(1);
        end
      end
      ST_OVER: begin
        if (start) begin
          state_s       = ST_PLAY;
          score_l_s     = SCORE_W'(0);
          score_r_s     = SCORE_W'(0);
          match_over_s  = 1'b0;
          champ_l_s     = 1'b0;
          champ_r_s     = 1'b0;
          field_reset_s = 1'b0;
          play_en_s     = 1'b1;
        end else begin
          field_reset_s = 1'b1;
          play_en_s     = 1'b0;
        end
      end
      default: begin
        state_s       = ST_IDLE;
        field_reset_s = 1'b1;
        play_en_s     = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      hold_cnt_r  <= HOLD_W'(0);
      score_l     <= SCORE_W'(0);
      score_r     <= SCORE_W'(0);
      field_reset <= 1'b1;
      play_en     <= 1'b0;
      match_over  <= 1'b0;
      champ_l     <= 1'b0;
      champ_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      hold_cnt_r  <= hold_cnt_s;
      score_l     <= score_l_s;
      score_r     <= score_r_s;
      field_reset <= field_reset_s;
      play_en     <= play_en_s;
      match_over  <= match_over_s;
      champ_l     <= champ_l_s;
      champ_r     <= champ_r_s;
    end
  end

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Self-checking bench for tug_match_ctrl (default build): directed scenarios plus random play against a behavioural model.
module tb_tug_match_ctrl;

  localparam int SW   = 3;
  localparam int WIN  = 7;
  localparam int HOLD = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          win_l;
  logic          win_r;
  logic          field_reset;
  logic          play_en;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          match_over;
  logic          champ_l;
  logic          champ_r;

  int tests = 0;
  int fails = 0;

  // Behavioural model: a match is running, finished, or pausing for some cycles.
  bit m_started;
  bit m_over;
  int m_pause;
  int m_sl;
  int m_sr;

  tug_match_ctrl #(.SCORE_W(SW), .WIN_SCORE(WIN), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .win_l(win_l), .win_r(win_r),
    .field_reset(field_reset), .play_en(play_en), .score_l(score_l), .score_r(score_r),
    .match_over(match_over), .champ_l(champ_l), .champ_r(champ_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit rs, input bit st, input bit wl, input bit wr);
    if (rs) begin
      m_started = 1'b0; m_over = 1'b0; m_pause = 0; m_sl = 0; m_sr = 0;
    end else if (!m_started || m_over) begin
      if (st) begin
        m_started = 1'b1; m_over = 1'b0; m_pause = 0; m_sl = 0; m_sr = 0;
      end
    end else if (m_pause > 0) begin
      m_pause--;
    end else if (wl != wr) begin
      if (wl) m_sl++; else m_sr++;
      if (m_sl == WIN || m_sr == WIN) m_over = 1'b1;
      else m_pause = HOLD;
    end
  endtask

  function automatic logic [10:0] expected();
    bit playing;
    playing = m_started && !m_over && (m_pause == 0);
    return {!playing, playing, m_over, m_over && (m_sl == WIN), m_over && (m_sr == WIN),
            SW'(m_sl), SW'(m_sr)};
  endfunction

  function automatic logic [10:0] observed();
    return {field_reset, play_en, match_over, champ_l, champ_r, score_l, score_r};
  endfunction

  task automatic tick(input bit rs, input bit st, input bit wl, input bit wr);
    reset = rs; start = st; win_l = wl; win_r = wr;
    @(posedge clk);
    model_step(rs, st, wl, wr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tests++;
    if (observed() !== 11'b10000_000_000) begin
      fails++; $display("FAIL reset_values got=%b exp=%b", observed(), 11'b10000_000_000);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (observed() !== expected() || play_en !== 1'b0) begin
      fails++; $display("FAIL idle_ignores_win got=%b exp=%b", observed(), expected());
    end
  endtask

  task automatic test_start();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (play_en !== 1'b1 || field_reset !== 1'b0 || score_l !== 3'd0 || score_r !== 3'd0) begin
      fails++; $display("FAIL start_to_play got pe=%b fr=%b sl=%0d sr=%0d exp pe=1 fr=0 0/0",
                        play_en, field_reset, score_l, score_r);
    end
  endtask

  task automatic test_single_win();
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (score_l !== 3'd1 || field_reset !== 1'b1 || play_en !== 1'b0) begin
      fails++; $display("FAIL win_l_score got sl=%0d fr=%b pe=%b exp sl=1 fr=1 pe=0",
                        score_l, field_reset, play_en);
    end
    for (int i = 0; i < HOLD; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL hold_window cyc=%0d got=%b exp=%b", i, observed(), expected());
      end
    end
    tests++;
    if (play_en !== 1'b1 || field_reset !== 1'b0 || score_l !== 3'd1) begin
      fails++; $display("FAIL hold_release got pe=%b fr=%b sl=%0d exp pe=1 fr=0 sl=1",
                        play_en, field_reset, score_l);
    end
  endtask

  task automatic test_tie();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      tests++;
      if (field_reset !== 1'b0 || play_en !== 1'b1 || score_l !== 3'd1 || score_r !== 3'd0) begin
        fails++; $display("FAIL tie_ignored cyc=%0d got fr=%b pe=%b sl=%0d sr=%0d exp fr=0 pe=1 1/0",
                          i, field_reset, play_en, score_l, score_r);
      end
    end
  endtask

  task automatic test_match_right();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < WIN; r++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL round_r%0d got=%b exp=%b", r, observed(), expected());
      end
      if (r < WIN - 1) begin
        for (int i = 0; i < HOLD; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    tests++;
    if (score_r !== 3'd7 || match_over !== 1'b1 || champ_r !== 1'b1 || champ_l !== 1'b0) begin
      fails++; $display("FAIL match_right got sr=%0d mo=%b cr=%b cl=%b exp 7 1 1 0",
                        score_r, match_over, champ_r, champ_l);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tests++;
      if (score_r !== 3'd7 || match_over !== 1'b1 || play_en !== 1'b0) begin
        fails++; $display("FAIL over_frozen got sr=%0d mo=%b pe=%b exp 7 1 0", score_r, match_over, play_en);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (observed() !== 11'b01000_000_000) begin
      fails++; $display("FAIL restart got=%b exp=%b", observed(), 11'b01000_000_000);
    end
  endtask

  task automatic test_reset_in_hold();
    for (int r = 0; r < 3; r++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      if (r < 2) begin
        for (int i = 0; i < HOLD; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (score_l !== 3'd3 || field_reset !== 1'b1) begin
      fails++; $display("FAIL hold_pre_reset got sl=%0d fr=%b exp 3 1", score_l, field_reset);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (observed() !== 11'b10000_000_000) begin
      fails++; $display("FAIL reset_in_hold got=%b exp=%b", observed(), 11'b10000_000_000);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      tests++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL random cyc=%0d got=%b exp=%b", c, observed(), expected());
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; win_l = 1'b0; win_r = 1'b0;
    m_started = 1'b0; m_over = 1'b0; m_pause = 0; m_sl = 0; m_sr = 0;
    @(negedge clk);
    test_reset();
    test_start();
    test_single_win();
    test_tie();
    test_match_right();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tug_match_ctrl.md
Name: tug_match_ctrl

Overview:
- Match-level sequencer for the tug-of-war game.
- Consumes the round winner detector's left/right win indications and keeps per-player scores.
- Holds the playfield (light chain and winner detector) in reset between rounds and declares the match champion at a target score.
- Sits between the round logic and the HEX score displays.

Parameters:
- SCORE_W, 3, width of each score counter.
- WIN_SCORE, 7, score that ends the match; must be ≤ 2^SCORE_W − 1.
- HOLD_CYCLES, 4, number of cycles field_reset is held after a round win, before play resumes; ≥ 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clock is clk.
- start  input  1  level; begins or restarts a match; sampled per cycle.
- win_l  input  1  left player won current round (asserted ≥ 1 cycle).
- win_r  input  1  right player won current round.
- field_reset  output  1  reset to playfield/winner detector.
- play_en  output  1  key inputs to playfield are enabled.
- score_l  output  SCORE_W  left score.
- score_r  output  SCORE_W  right score.
- match_over  output  1  match finished.
- champ_l  output  1  left player won the match.
- champ_r  output  1  right player won the match.

Behaviour:
- All outputs registered.
- Reset values: state IDLE, score_l = score_r = 0, field_reset = 1, play_en = 0, match_over = 0, champ_l = champ_r = 0.
- reset has priority over every other input in every state, including mid-hold and MATCH_OVER.
- States: IDLE, PLAY, HOLD, OVER.
- IDLE:
  - field_reset = 1, play_en = 0.
  - start = 1 → PLAY next cycle; field_reset = 0, play_en = 1 from that cycle.
- PLAY:
  - field_reset = 0, play_en = 1.
  - Exactly one of win_l/win_r high at edge t → winner's score += 1 visible at t+1.
  - If the new score == WIN_SCORE → OVER at t+1.
  - Otherwise → HOLD at t+1, with field_reset = 1 and play_en = 0 at t+1.
  - win_l & win_r both high → tie, ignored, stay PLAY.
  - start ignored.
- HOLD:
  - field_reset = 1, play_en = 0 for exactly HOLD_CYCLES cycles (t+1 .. t+HOLD_CYCLES), using an internal down-counter loaded on entry.
  - Then → PLAY: field_reset = 0 at t+HOLD_CYCLES+1.
  - Win inputs and start ignored; a win held high across the hold is not re-counted because field_reset clears the detector.
- OVER:
  - field_reset = 1, play_en = 0, match_over = 1.
  - champ_l/champ_r = 1 for the player who reached WIN_SCORE; the other = 0.
  - Scores frozen.
  - start = 1 → scores cleared to 0, champ/match_over cleared, → PLAY next cycle.
- Win inputs in IDLE or OVER are ignored.
- A score never exceeds WIN_SCORE and never wraps.
- champ_l and champ_r are never both 1.

Optional Feature:
- Macro: TUG_WIN_BY_TWO_EN.
- Defined:
  - Match ends only when the winner's new score ≥ WIN_SCORE and leads by ≥ 2.
  - If both scores would reach 2^SCORE_W − 1, both are decremented by 1 in the same cycle, preserving the difference, so there is no overflow.
- Undefined:
  - First player to WIN_SCORE wins.
  - No decrement logic is synthesized.

Test Plan:
- reset → start=1 for 1 cycle → next cycle play_en=1, field_reset=0, scores 0/0.
- In PLAY, win_l pulse at edge t → score_l=1 at t+1; field_reset=1 for cycles t+1..t+4 (HOLD_CYCLES=4); play_en=1 at t+5.
- win_l=win_r=1 for 3 cycles in PLAY → scores unchanged, state PLAY, field_reset stays 0.
- Seven win_r rounds → score_r=7, match_over=1, champ_r=1, champ_l=0; further win_r pulses leave score_r=7; start → 0/0, PLAY.
- reset asserted during HOLD (score_l=3) → next cycle IDLE, scores 0, field_reset=1, play_en=0.
- TUG_WIN_BY_TWO_EN defined, scores reach 6/6, then win_l → 7/6, match_over stays 0; then win_l → 8/6, match_over=1, champ_l=1. (Needs SCORE_W=4; with SCORE_W=3, from 7/6 a win_r gives 6/6 after the decrement.)
